// File: rtl/fpu_pkg.sv
// Shared types and constants for the single-precision FP multiplier path.
// Used by the operand loader and the multiplier datapath.
package fpu_pkg;

   typedef enum logic [1:0] {
      S_A    = 2'd0,
      S_B    = 2'd1,
      S_CALC = 2'd2,
      S_SHOW = 2'd3
   } loader_state_t;

   localparam int SPC_POS_ZERO = 4;
   localparam int SPC_NEG_ZERO = 3;
   localparam int SPC_POS_INF  = 2;
   localparam int SPC_NEG_INF  = 1;
   localparam int SPC_NAN      = 0;

   localparam logic [7:0] FP_EXP_ONES = 8'hFF;
   localparam int         FP_BIAS     = 127;

endpackage

// File: rtl/fpu_operand_loader_rise_pulse.sv
// One-flop rising-edge detector; emits a single-cycle pulse per
// low-to-high transition of level_i.
module rise_pulse (
   input  logic clk,
   input  logic rst,
   input  logic level_i,
   output logic pulse_o
);

   logic level_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) level_q <= 1'b0;
      else     level_q <= level_i;
   end

   assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/fpu_operand_loader.sv
// Byte-serial operand loader for the FP multiplier: shifts in A then B,
// captures the product and flags once, then holds them for display.
module fpu_operand_loader
   import fpu_pkg::*;
#(
   parameter int BYTE_W          = 8,
   parameter int WORD_W          = 32,
   parameter bit LOAD_ACTIVE_LOW = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] data_in,
   input  logic              load,
   input  logic              clear,
   output logic [WORD_W-1:0] mul_a,
   output logic [WORD_W-1:0] mul_b,
   input  logic [WORD_W-1:0] mul_result,
   input  logic [4:0]        mul_special,
   output logic [WORD_W-1:0] result,
   output logic [4:0]        special,
   output logic              done,
   output logic [1:0]        phase,
   output logic [1:0]        byte_idx
);

   localparam int         NUM_BYTES = WORD_W / BYTE_W;
   localparam logic [1:0] LAST_IDX  = 2'(NUM_BYTES - 1);

   logic load_act;
   logic clr_act;
   logic load_pulse;

   loader_state_t     state_q;
   logic [1:0]        idx_q;
   logic [WORD_W-1:0] a_q;
   logic [WORD_W-1:0] b_q;
   logic [WORD_W-1:0] res_q;
   logic [4:0]        spc_q;
   logic              done_q;

   assign load_act = LOAD_ACTIVE_LOW ? ~load  : load;
   assign clr_act  = LOAD_ACTIVE_LOW ? ~clear : clear;

   rise_pulse u_load_edge (
      .clk     (clk),
      .rst     (rst),
      .level_i (load_act),
      .pulse_o (load_pulse)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_A;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         spc_q   <= '0;
         done_q  <= 1'b0;
      end else if (clr_act) begin
         // clear outranks any load edge landing in the same cycle
         state_q <= S_A;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         spc_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_A: if (load_pulse) begin
               a_q <= {a_q[WORD_W-BYTE_W-1:0], data_in};
               if (idx_q == LAST_IDX) begin
                  idx_q   <= '0;
                  state_q <= S_B;
               end else begin
                  idx_q <= idx_q + 2'd1;
               end
            end
            S_B: if (load_pulse) begin
               b_q <= {b_q[WORD_W-BYTE_W-1:0], data_in};
               if (idx_q == LAST_IDX) begin
                  idx_q   <= '0;
                  state_q <= S_CALC;
               end else begin
                  idx_q <= idx_q + 2'd1;
               end
            end
            S_CALC: begin
               res_q   <= mul_result;
               spc_q   <= mul_special;
               done_q  <= 1'b1;
               state_q <= S_SHOW;
            end
            S_SHOW: if (load_pulse) begin
               // the restarting press is already the first byte of A
               a_q     <= WORD_W'(data_in);
               b_q     <= '0;
               idx_q   <= 2'd1;
               done_q  <= 1'b0;
               state_q <= S_A;
            end
         endcase
      end
   end

   assign mul_a    = a_q;
   assign mul_b    = b_q;
   assign result   = res_q;
   assign special  = spc_q;
   assign done     = done_q;
   assign phase    = state_q;
   assign byte_idx = idx_q;

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Bench for fpu_operand_loader: directed vectors, corner sequences and
// randomized traffic against a byte-list reference model.
module tb_fpu_operand_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  data_in = 8'h00;
   logic        load = 1'b1;
   logic        clear = 1'b1;
   logic [31:0] mul_a, mul_b, mul_result, result;
   logic [4:0]  mul_special, special;
   logic        done;
   logic [1:0]  phase, byte_idx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fpu_operand_loader dut (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .load        (load),
      .clear       (clear),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_result  (mul_result),
      .mul_special (mul_special),
      .result      (result),
      .special     (special),
      .done        (done),
      .phase       (phase),
      .byte_idx    (byte_idx)
   );

   // stand-in multiplier: exact for the directed pairs, IEEE special rules
   function automatic logic [36:0] mul_stub(input logic [31:0] a, input logic [31:0] b);
      logic an, bn, ai, bi, az, bz, s;
      an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      az = (a[30:0] == 0);
      bz = (b[30:0] == 0);
      s  = a[31] ^ b[31];
      if (an || bn || (az && bi) || (ai && bz))
         return {5'b00001, 32'h7FC0_0000};
      if (ai || bi)
         return {(s ? 5'b00010 : 5'b00100), s, 8'hFF, 23'd0};
      if (az || bz)
         return {(s ? 5'b01000 : 5'b10000), s, 31'd0};
      if (a == 32'h40FC_0000 && b == 32'h3E40_0000)
         return {5'b0, 32'h3FBD_0000};
      if (a == 32'hC190_0000 && b == 32'h4118_0000)
         return {5'b0, 32'hC32B_0000};
      return {5'b0, a ^ {b[15:0], b[31:16]} ^ 32'h1357_9BDF};
   endfunction

   always_comb {mul_special, mul_result} = mul_stub(mul_a, mul_b);

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic press(input logic [7:0] b);
      data_in = b;
      load = 1'b0;
      @(negedge clk);
      load = 1'b1;
      @(negedge clk);
   endtask

   typedef struct {
      logic [63:0] bytes;
      logic [31:0] a, b, res;
      logic [4:0]  spc;
   } vec_t;

   // reference model: list of bytes received plus a show flag
   int          mn;
   logic [7:0]  mb [8];
   bit          mshow;
   logic [31:0] mres;
   logic [4:0]  mspc;
   bit          mprev;

   function automatic logic [31:0] pack(input int first, input int cnt);
      logic [31:0] v = '0;
      for (int i = 0; i < cnt; i++) v = (v << 8) | 32'(mb[first + i]);
      return v;
   endfunction

   function automatic logic [31:0] model_a();
      return pack(0, (mn < 4) ? mn : 4);
   endfunction

   function automatic logic [31:0] model_b();
      return (mn > 4) ? pack(4, mn - 4) : 32'd0;
   endfunction

   vec_t vt [3];

   initial begin
      vt[0] = '{64'h40FC_0000_3E40_0000, 32'h40FC_0000, 32'h3E40_0000, 32'h3FBD_0000, 5'b00000};
      vt[1] = '{64'hC190_0000_4118_0000, 32'hC190_0000, 32'h4118_0000, 32'hC32B_0000, 5'b00000};
      vt[2] = '{64'h0000_0000_7F80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 5'b00001};

      repeat (2) @(negedge clk);
      chk("rst_phase", 32'(phase), 0);
      chk("rst_done", 32'(done), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_a", mul_a, 0);
      chk("reset_b", mul_b, 0);
      chk("reset_res", result, 0);
      chk("reset_spc", 32'(special), 0);
      chk("reset_idx", 32'(byte_idx), 0);

      for (int v = 0; v < 3; v++) begin
         logic [63:0] bs;
         bs = vt[v].bytes;
         for (int i = 0; i < 7; i++) press(bs[63-8*i -: 8]);
         chk("pre8_phase", 32'(phase), 1);
         chk("pre8_idx", 32'(byte_idx), 3);
         data_in = bs[7:0];
         load = 1'b0;
         @(negedge clk);
         chk("calc_phase", 32'(phase), 2);
         chk("calc_done", 32'(done), 0);
         load = 1'b1;
         @(negedge clk);
         chk("vec_a", mul_a, vt[v].a);
         chk("vec_b", mul_b, vt[v].b);
         chk("vec_res", result, vt[v].res);
         chk("vec_spc", 32'(special), 32'(vt[v].spc));
         chk("vec_done", 32'(done), 1);
         chk("vec_phase", 32'(phase), 3);
         chk("vec_idx", 32'(byte_idx), 0);
      end

      // held button: one shift only
      clear = 1'b0;
      @(negedge clk);
      clear = 1'b1;
      chk("clr_done", 32'(done), 0);
      chk("clr_res", result, 0);
      data_in = 8'hAB;
      load = 1'b0;
      repeat (5) @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      chk("hold_a", mul_a, 32'h0000_00AB);
      chk("hold_idx", 32'(byte_idx), 1);

      // clear together with a load edge in S_B
      for (int i = 0; i < 5; i++) press(8'(i + 1));
      chk("sb_phase", 32'(phase), 1);
      chk("sb_idx", 32'(byte_idx), 2);
      data_in = 8'h77;
      load = 1'b0;
      clear = 1'b0;
      @(negedge clk);
      chk("clrld_phase", 32'(phase), 0);
      chk("clrld_idx", 32'(byte_idx), 0);
      chk("clrld_a", mul_a, 0);
      chk("clrld_b", mul_b, 0);
      chk("clrld_done", 32'(done), 0);
      load = 1'b1;
      clear = 1'b1;
      @(negedge clk);

      // restart from S_SHOW
      for (int i = 0; i < 8; i++) press(vt[0].bytes[63-8*i -: 8]);
      press(8'h3F);
      chk("rs_phase", 32'(phase), 0);
      chk("rs_done", 32'(done), 0);
      chk("rs_a", mul_a, 32'h0000_003F);
      chk("rs_b", mul_b, 0);
      chk("rs_idx", 32'(byte_idx), 1);
      chk("rs_res", result, 32'h3FBD_0000);

      // async reset between edges
      for (int i = 0; i < 8; i++) press(vt[1].bytes[63-8*i -: 8]);
      press(8'h12);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_a", mul_a, 0);
      chk("arst_res", result, 0);
      chk("arst_phase", 32'(phase), 0);
      chk("arst_idx", 32'(byte_idx), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      press(8'h5A);
      chk("post_rst_a", mul_a, 32'h0000_005A);
      chk("post_rst_idx", 32'(byte_idx), 1);

      // randomized traffic against the model
      clear = 1'b0;
      @(negedge clk);
      clear = 1'b1;
      mn = 0; mshow = 0; mres = '0; mspc = '0; mprev = 0;
      for (int c = 0; c < 2000; c++) begin
         bit act, clr, pulse;
         logic [36:0] cap;
         act = ($urandom_range(0, 1) == 1);
         clr = ($urandom_range(0, 59) == 0);
         data_in = 8'($urandom);
         load = ~act;
         clear = ~clr;
         pulse = act & ~mprev;
         mprev = act;
         if (clr) begin
            mn = 0; mshow = 0; mres = '0; mspc = '0;
         end else if (mn == 8 && !mshow) begin
            cap = mul_stub(model_a(), model_b());
            mshow = 1;
            mspc = cap[36:32];
            mres = cap[31:0];
         end else if (mshow) begin
            if (pulse) begin
               mshow = 0;
               mb[0] = data_in;
               mn = 1;
            end
         end else if (pulse) begin
            mb[mn] = data_in;
            mn++;
         end
         @(negedge clk);
         chk("rnd_a", mul_a, model_a());
         chk("rnd_b", mul_b, model_b());
         chk("rnd_res", result, mres);
         chk("rnd_spc", 32'(special), 32'(mspc));
         chk("rnd_done", 32'(done), 32'(mshow));
         chk("rnd_phase", 32'(phase), mshow ? 3 : (mn == 8) ? 2 : (mn >= 4) ? 1 : 0);
         chk("rnd_idx", 32'(byte_idx), (mn == 8) ? 0 : (mn % 4));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
